// File: rtl/axi_pkg.sv
// Shared AXI3 responder definitions: response codes, ID width and FSM encodings.
package axi_pkg;
  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_MEM = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  // Latched burst context; len is the beat count minus one (AXI3 len[3:0]).
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      len;
    logic [3:0]      beat;
  } burst_t;
endpackage

// File: rtl/sram_sp.sv
// Single-port byte-writable SRAM; read data is registered and only moves on a read.
module sram_sp
  import axi_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [STRB_W-1:0][7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) mem_q[addr][b] <= din[8*b +: 8];
      end
    end
  end

  // Writes leave dout alone so a beat waiting on rready keeps its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dout <= '0;
    else if (en && we == '0)   dout <= mem_q[addr];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 INCR-only responder over a single-port SRAM; write beats win the port over reads.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);
  logic              rdy_en_q;
  r_state_e          r_state_q, r_state_d;
  w_state_e          w_state_q, w_state_d;
  burst_t            rb_q, rb_d, wb_q, wb_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              wr_fire, rd_issue;
  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       arsize, awsize, arburst, awburst, arlen[7:4], awlen[7:4],
                       araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

  // Ready-enable flop keeps arready/awready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      rb_q      <= '0;
      raddr_q   <= '0;
      w_state_q <= W_IDLE;
      wb_q      <= '0;
      waddr_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rb_q      <= rb_d;
      raddr_q   <= raddr_d;
      w_state_q <= w_state_d;
      wb_q      <= wb_d;
      waddr_q   <= waddr_d;
      err_q     <= err_d;
    end
  end

  assign wready  = (w_state_q == W_DATA);
  assign wr_fire = wready && wvalid;

  always_comb begin
    w_state_d = w_state_q;
    wb_d      = wb_q;
    waddr_d   = waddr_q;
    err_d     = err_q;
    case (w_state_q)
      W_IDLE: if (rdy_en_q && awvalid) begin
        wb_d      = '{id: awid, len: awlen[3:0], beat: 4'd0};
        waddr_d   = awaddr[ADDR_W+1:2];
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        // Burst length comes from awlen; wlast is only checked, never obeyed.
        if (wlast != (wb_q.beat == wb_q.len)) err_d = 1'b1;
        if (wb_q.beat == wb_q.len) begin
          w_state_d = W_RESP;
        end else begin
          wb_d.beat = wb_q.beat + 4'd1;
          waddr_d   = waddr_q + ADDR_W'(1);
        end
      end
      W_RESP: if (bready) begin
        err_d     = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rb_d      = rb_q;
    raddr_d   = raddr_q;
    rd_issue  = 1'b0;
    case (r_state_q)
      R_IDLE: if (rdy_en_q && arvalid) begin
        rb_d      = '{id: arid, len: arlen[3:0], beat: 4'd0};
        raddr_d   = araddr[ADDR_W+1:2];
        r_state_d = R_MEM;
      end
      R_MEM: if (!wr_fire) begin
        rd_issue  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rb_q.beat == rb_q.len) begin
          r_state_d = R_IDLE;
        end else begin
          rb_d.beat = rb_q.beat + 4'd1;
          raddr_d   = raddr_q + ADDR_W'(1);
          r_state_d = R_MEM;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // A zero-strobe beat still holds off the read but touches nothing.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = '0;
    sram_addr = raddr_q;
    if (wr_fire) begin
      sram_en   = |wstrb;
      sram_we   = wstrb;
      sram_addr = waddr_q;
    end else if (rd_issue) begin
      sram_en   = 1'b1;
    end
  end

  sram_sp #(.ADDR_W(ADDR_W)) u_sram (
    .clk   (clk),
    .rst_n (reset),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .din   (wdata),
    .dout  (rdata)
  );

  assign arready = rdy_en_q && (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && (rb_q.beat == rb_q.len);
  assign rid     = rb_q.id;
  assign rresp   = RESP_OKAY;

  assign awready = rdy_en_q && (w_state_q == W_IDLE);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = wb_q.id;
  assign bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: vector table of single-beat write/readback plus burst corner sequences.
module tb_axi_sram_slave;
  logic        clk, reset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_slave #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] id; logic last; } rexp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [3:0] id; logic [31:0] exp; } vec_t;

  int          n_vec = 0, n_err = 0;
  int          rr_mode = 0;   // 0: rready high, 1: toggle each cycle, 2: rready low
  logic [31:0] mdl [4096];
  rexp_t       rq[$];
  bexp_t       bq[$];
  rexp_t       re;
  bexp_t       be;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  vec_t        tbl [7];

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic rexp_t mk_r(input logic [31:0] d, input logic [3:0] id, input logic last);
    rexp_t r;
    r.d = d; r.id = id; r.last = last;
    return r;
  endfunction

  function automatic void push_rd_model(input logic [31:0] addr, input int len, input logic [3:0] id);
    logic [11:0] w;
    for (int i = 0; i <= len; i++) begin
      w = addr[13:2] + 12'(i);
      rq.push_back(mk_r(mdl[w], id, i == len));
    end
  endfunction

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0)      rready = 1'b1;
      else if (rr_mode == 1) rready = ~rready;
      else                   rready = 1'b0;
    end
  end

  // R scoreboard: pop on handshake, and check rdata holds while stalled.
  initial forever begin
    @(negedge clk);
    if (rvalid === 1'b1) begin
      if (hold_v) chk("rdata_hold", rdata, hold_d);
      if (rready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'(rq.size() + 1), 32'd0);
        else begin
          re = rq.pop_front();
          chk("rdata", rdata, re.d);
          chk("rid",   32'(rid), 32'(re.id));
          chk("rlast", 32'(rlast), 32'(re.last));
          chk("rresp", 32'(rresp), 32'd0);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = rdata;
      end
    end else hold_v = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (bvalid === 1'b1 && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'(bq.size() + 1), 32'd0);
      else begin
        be = bq.pop_front();
        chk("bid",   32'(bid), 32'(be.id));
        chk("bresp", 32'(bresp), 32'(be.resp));
      end
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [3:0] id);
    int n;
    logic err;
    logic [11:0] w;
    bexp_t b;
    err = 1'b0;
    for (int i = 0; i <= len; i++) if (wl[i] != (i == len)) err = 1'b1;
    b.id = id; b.resp = err ? 2'b10 : 2'b00;
    bq.push_back(b);
    @(negedge clk);
    awaddr = addr; awlen = 8'(len); awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wid = id; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (!wready) chk("w_timeout", 32'(wready), 32'd1);
      w = addr[13:2] + 12'(i);
      for (int b2 = 0; b2 < 4; b2++) if (ws[i][b2]) mdl[w][8*b2 +: 8] = wd[i][8*b2 +: 8];
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // lat counts negedges from the handshake cycle to the first rvalid.
  task automatic ar_send(input logic [31:0] addr, input int len, input logic [3:0] id,
                         input bit chk_lat, output int lat);
    int n;
    @(negedge clk);
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 200) begin @(negedge clk); lat++; end
    if (chk_lat) chk("ar_to_rvalid", 32'(lat), 32'd2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain", 32'(rq.size() + bq.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int lat, n2;
    logic [3:0] rd_id;
    tbl[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'h1, 32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_0040, 32'h1122_3344, 4'hF, 4'h3, 32'h1122_3344};
    tbl[2] = '{32'h0000_0040, 32'hAA00_0000, 4'h8, 4'h4, 32'hAA22_3344};
    tbl[3] = '{32'h0000_0043, 32'h0000_00BB, 4'h1, 4'h5, 32'hAA22_33BB};
    tbl[4] = '{32'h0000_4100, 32'h0123_4567, 4'h3, 4'h6, 32'hDEAD_4567};
    tbl[5] = '{32'h0000_FFFC, 32'hCAFE_F00D, 4'hF, 4'h7, 32'hCAFE_F00D};
    tbl[6] = '{32'h0000_FFFC, 32'h1234_5678, 4'h0, 4'h8, 32'hCAFE_F00D};

    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
    arcache = '0; arprot = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 0);  chk("rst_awready", 32'(awready), 0);
    chk("rst_wready",  32'(wready), 0);   chk("rst_rvalid",  32'(rvalid), 0);
    chk("rst_bvalid",  32'(bvalid), 0);   chk("rst_rlast",   32'(rlast), 0);
    chk("rst_rid",     32'(rid), 0);      chk("rst_bid",     32'(bid), 0);
    chk("rst_rresp",   32'(rresp), 0);    chk("rst_bresp",   32'(bresp), 0);
    chk("rst_rdata",   rdata, 0);
    reset = 1'b1;
    #1 chk("arready_before_edge", 32'(arready), 0);
    @(negedge clk);
    chk("arready_after_edge", 32'(arready), 1);
    chk("awready_after_edge", 32'(awready), 1);

    // Single-beat write/readback vectors: strobes, ignored addr[1:0], depth wrap.
    for (int i = 0; i < 7; i++) begin
      wd[0] = tbl[i].data; ws[0] = tbl[i].strb; wl[0] = 1'b1;
      wr_burst(tbl[i].addr, 0, tbl[i].id);
      drain();
      rd_id = tbl[i].id + 4'd1;
      rq.push_back(mk_r(tbl[i].exp, rd_id, 1'b1));
      ar_send(tbl[i].addr, 0, rd_id, i == 0, lat);
      drain();
    end

    // 4-beat burst read back with rready toggling.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; wl[i] = (i == 3); end
    wr_burst(32'h200, 3, 4'h3);
    drain();
    rr_mode = 1;
    for (int i = 0; i < 4; i++) rq.push_back(mk_r(32'(i), 4'h9, i == 3));
    ar_send(32'h200, 3, 4'h9, 1'b0, lat);
    drain();
    rr_mode = 0;

    // Early wlast, then clean, then missing wlast, then clean.
    wd[0] = 32'h0A0A_0A0A; wd[1] = 32'h0B0B_0B0B; ws[0] = 4'hF; ws[1] = 4'hF;
    wl[0] = 1'b1; wl[1] = 1'b1;
    wr_burst(32'h500, 1, 4'hA);
    drain();
    rq.push_back(mk_r(32'h0A0A_0A0A, 4'hB, 1'b0));
    rq.push_back(mk_r(32'h0B0B_0B0B, 4'hB, 1'b1));
    ar_send(32'h500, 1, 4'hB, 1'b0, lat);
    drain();
    wd[0] = 32'h0C0C_0C0C; wl[0] = 1'b1;
    wr_burst(32'h510, 0, 4'hC);
    drain();
    wd[0] = 32'h0D0D_0D0D; wd[1] = 32'h0E0E_0E0E; wl[0] = 1'b0; wl[1] = 1'b0;
    wr_burst(32'h520, 1, 4'hD);
    drain();
    wd[0] = 32'h0F0F_0F0F; wl[0] = 1'b1;
    wr_burst(32'h530, 0, 4'hE);
    drain();
    push_rd_model(32'h510, 8, 4'h2);
    ar_send(32'h510, 8, 4'h2, 1'b0, lat);
    drain();

    // Read of the region a 16-beat write is streaming into: must wait and see new data.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h3000_0000 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 15); end
    fork
      wr_burst(32'h300, 15, 4'h4);
      begin
        n2 = 0;
        while (!(wvalid && wready) && n2 < 200) begin @(negedge clk); n2++; end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) rq.push_back(mk_r(32'h3000_0000 + 32'(i), 4'h6, i == 3));
        ar_send(32'h300, 3, 4'h6, 1'b0, lat);
        chk("collision_stall", 32'(lat > 10), 32'd1);
      end
    join
    drain();

    // Reset while an 8-beat read is stalled on rready.
    rr_mode = 2;
    ar_send(32'h300, 7, 4'h7, 1'b0, lat);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_rvalid",  32'(rvalid), 0);
    chk("midrst_rlast",   32'(rlast), 0);
    chk("midrst_rdata",   rdata, 0);
    chk("midrst_arready", 32'(arready), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rel_arready_before_edge", 32'(arready), 0);
    @(negedge clk);
    chk("rel_arready", 32'(arready), 1);
    chk("rel_awready", 32'(awready), 1);
    rr_mode = 0;
    push_rd_model(32'h300, 7, 4'h8);
    ar_send(32'h300, 7, 4'h8, 1'b1, lat);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address bits (4096 x 32-bit words, 16 KB).
REQ-002 SHALL have ports clk in 1 (the single clock) and reset in 1 (asynchronous, active-low).
REQ-003 SHALL have AR ports: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-004 SHALL have R ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-005 SHALL have AW ports: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-006 SHALL have W ports wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1, and B ports bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-007 SHALL accept and ignore arlock/arcache/arprot/awlock/awcache/awprot; wid, arsize, awsize, arburst and awburst are ignored.

Function
REQ-008 SHALL be an AXI3 responder; all bursts are INCR, 32-bit beats, length = len[3:0]+1 (1..16); len[7:4] ignored.
REQ-009 SHALL index memory by addr[ADDR_W+1:2], wrapping modulo depth; addr[1:0] ignored; beat address increments by 1 word.
REQ-010 SHALL run read FSM R_IDLE -> R_MEM -> R_DATA; arready=1 only in R_IDLE (after reset release); AR handshake latches arid, address and length.
REQ-011 In R_MEM, SHALL issue the SRAM read when the port is free and advance to R_DATA; if a write beat owns the port, SHALL stay in R_MEM.
REQ-012 In R_DATA, SHALL drive rvalid=1 with rdata, rid, rresp=2'b00 and rlast (last beat) stable until rready.
REQ-013 On R handshake: last beat -> R_IDLE; otherwise increment address -> R_MEM; uncontended AR-handshake-to-first-rvalid latency = 2 cycles, beat spacing = 2 cycles.
REQ-014 SHALL run write FSM W_IDLE -> W_DATA -> W_RESP; awready=1 only in W_IDLE; AW handshake latches awid, address and length, clears the beat counter.
REQ-015 In W_DATA, SHALL hold wready=1; each W handshake writes wdata under wstrb byte enables in the same cycle.
REQ-016 SHALL end the burst on beat count (beat == len), not on wlast; any beat where wlast != (beat == len) sets a sticky error flag.
REQ-017 In W_RESP, SHALL drive bvalid=1, bid = latched awid, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00; on bready SHALL clear the flag -> W_IDLE.
REQ-018 Single SRAM port: W beat has priority over R_MEM read in the same cycle; the read stalls at most one burst (no write beats in W_RESP).
REQ-019 SRAM read output SHALL change only on a read enable, so rdata stays stable across intervening writes while in R_DATA.
REQ-020 A write then read to the same word SHALL return the new data (write cycle precedes read cycle).
REQ-021 AR and AW SHALL be independent; one read and one write burst may be outstanding simultaneously; no read reordering (one read outstanding).

Reset
REQ-022 While reset=0: both FSMs idle; arready, awready, wready, rvalid, bvalid, rlast = 0; rid, bid, rresp, bresp, rdata = 0; error flag and counters cleared.
REQ-023 arready/awready SHALL assert on the first clk edge after reset deasserts (registered ready-enable flop).
REQ-024 Reset mid-burst SHALL abort immediately with no response; SRAM contents are not cleared.

Structure
REQ-025 Shared package axi_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the read/write FSM state encodings and ID width 4.
REQ-026 Sub-module sram_sp SHALL be the single-port, 32-bit, byte-write SRAM with 1-cycle registered read (en, we[3:0], addr, din, dout).

Verification
REQ-027 Single write: AW 0x100 len0 id 1; W 0xDEADBEEF strb 0xF wlast=1 -> bvalid, bid=1, bresp=00; read 0x100 id 2 -> rdata 0xDEADBEEF, rid=2, rlast=1, rvalid 2 cycles after AR handshake.
REQ-028 Byte strobe: write 0x11223344 then 0xAA00_0000 strb 0x8 to 0x40 -> read 0xAA223344.
REQ-029 Burst: 4-beat write 0,1,2,3 at 0x200 with rready toggling every other cycle on 4-beat read -> data 0..3 in order, rlast on beat 4 only, rdata held while rready=0.
REQ-030 Collision: read burst pending at R_MEM while 16-beat write streams -> read stalls, completes after write beats, correct data.
REQ-031 Protocol error: len1 write with wlast=1 on beat 0 -> two beats written, bresp=2'b10; next clean write -> bresp=00.
REQ-032 Reset asserted mid 8-beat read -> rvalid=0 immediately; arready=1 one edge after release; new read returns correct data.
